// File: rtl/serial_frame_pkg.sv
// Constants and state encoding shared by the serial framing blocks (serial2mem, mem2serial).
package serial_frame_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_WORD    = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        WRITE   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/rx_timeout.sv
// Idle-cycle counter: clear restarts it, enable advances it, terminal flags LIMIT-1 reached.
module rx_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int             CW   = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    // Saturates at the terminal value so it never wraps back into a false idle window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign terminal = (count_reg == LAST);

endmodule

// File: rtl/serial2mem.sv
// Reassembles SYNC + data bytes + XOR checksum frames from the UART into FIFO word writes.
module serial2mem
    import serial_frame_pkg::*;
#(
    parameter int         DATA_WIDTH     = BYTES_PER_WORD * 8,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_valid,
    input  logic [7:0]            uart_data,
    input  logic                  write_full,
    output logic                  write_clock_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  frame_error,
    output logic [7:0]            drop_count
);

    localparam int                BYTES     = DATA_WIDTH / 8;
    localparam int                CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);

    frame_state_t          state_reg,    state_next;
    logic [CNT_W-1:0]      byte_cnt_reg, byte_cnt_next;
    logic [7:0]            csum_reg,     csum_next;
    logic [DATA_WIDTH-1:0] word_reg,     word_next;
    logic [DATA_WIDTH-1:0] data_reg,     data_next;
    logic                  we_reg,       we_next;
    logic                  err_reg,      err_next;
    logic [7:0]            drop_reg,     drop_next;
    logic [DATA_WIDTH-1:0] shifted_word;
    logic                  in_frame;
    logic                  timeout_hit;

    // New byte enters lane 0; every older byte moves up one lane, so the first lands on top.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign shifted_word[7:0] = uart_data;
            end else begin : g_rest
                assign shifted_word[gi*8 +: 8] = word_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    assign in_frame = (state_reg == COLLECT) || (state_reg == CHECK);

    rx_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (uart_valid || !in_frame),
        .enable   (1'b1),
        .terminal (timeout_hit)
    );

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        csum_next     = csum_reg;
        word_next     = word_reg;
        data_next     = data_reg;
        we_next       = 1'b0;
        err_next      = 1'b0;
        drop_next     = drop_reg;

        case (state_reg)
            IDLE, WRITE: begin
                // WRITE lasts one cycle and uses IDLE rules, so a SYNC here is not lost.
                state_next = IDLE;
                if (uart_valid && (uart_data == SYNC_BYTE)) begin
                    state_next    = COLLECT;
                    byte_cnt_next = '0;
                    csum_next     = '0;
                end
            end
            COLLECT: begin
                if (uart_valid) begin
                    word_next     = shifted_word;
                    csum_next     = csum_reg ^ uart_data;
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        state_next = CHECK;
                    end
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                if (uart_valid) begin
                    if (uart_data == csum_reg) begin
                        // Full is sampled here so the strobe leaves a register in the WRITE cycle.
                        state_next = WRITE;
                        data_next  = word_reg;
                        if (write_full) begin
                            drop_next = (drop_reg == 8'hFF) ? drop_reg : drop_reg + 8'd1;
                        end else begin
                            we_next = 1'b1;
                        end
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
            word_reg     <= '0;
            data_reg     <= '0;
            we_reg       <= 1'b0;
            err_reg      <= 1'b0;
            drop_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            csum_reg     <= csum_next;
            word_reg     <= word_next;
            data_reg     <= data_next;
            we_reg       <= we_next;
            err_reg      <= err_next;
            drop_reg     <= drop_next;
        end
    end

    assign write_clock_enable = we_reg;
    assign write_data         = data_reg;
    assign frame_error        = err_reg;
    assign drop_count         = drop_reg;

endmodule
